// File: rtl/traffic_lamp_monitor_if.sv
// Lamp request / lamp drive bundle between a traffic light controller and the
// lamp monitor. The controller side (master) drives the requests and the
// operator acknowledge; the monitor side (slave) drives the lamps and status.
interface traffic_lamp_monitor_if;
  // lamp requests from the controller
  logic       NS_red;
  logic       NS_yellow;
  logic       NS_green;
  logic       EW_red;
  logic       EW_yellow;
  logic       EW_green;
  // operator fault acknowledge
  logic       fault_clr;
  // registered lamp drives
  logic       NS_red_o;
  logic       NS_yellow_o;
  logic       NS_green_o;
  logic       EW_red_o;
  logic       EW_yellow_o;
  logic       EW_green_o;
  // status
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, fault_clr,
    input  NS_red_o, NS_yellow_o, NS_green_o, EW_red_o, EW_yellow_o, EW_green_o,
    input  fault, fault_code
  );

  modport slave (
    input  NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, fault_clr,
    output NS_red_o, NS_yellow_o, NS_green_o, EW_red_o, EW_yellow_o, EW_green_o,
    output fault, fault_code
  );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// Traffic lamp safety monitor. Sits between the light controller and the lamp
// drivers: forces all-red during startup, passes requests through with one
// cycle of latency while they are legal, and latches into a red-flash FAULT
// state on an illegal lamp pattern, a green/green conflict or a too-short
// green/yellow dwell. Only an operator acknowledge or reset leaves FAULT.
// Lamp vectors are packed {red, yellow, green}.
module traffic_lamp_monitor #(
  parameter int STARTUP_CYCLES = 16,
  parameter int MIN_GREEN      = 8,
  parameter int MIN_YELLOW     = 3,
  parameter int BLINK_HALF     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_lamp_monitor_if.slave bus
);

  localparam int             SW         = $clog2(STARTUP_CYCLES) + 1;
  localparam int             BW         = $clog2(BLINK_HALF) + 1;
  localparam logic [SW-1:0]  START_LAST = SW'(STARTUP_CYCLES - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [7:0]     MIN_G8     = 8'(MIN_GREEN);
  localparam logic [7:0]     MIN_Y8     = 8'(MIN_YELLOW);
  localparam logic [2:0]     COL_YELLOW = 3'b010;
  localparam logic [2:0]     COL_GREEN  = 3'b001;
  localparam logic [2:0]     COL_RED    = 3'b100;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // A direction is legal only with exactly one lamp lit.
  function automatic logic lamp_valid(input logic [2:0] lamps);
    logic ok;
    case (lamps)
      3'b001:  ok = 1'b1;
      3'b010:  ok = 1'b1;
      3'b100:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Dwell counter update: restart at 1 on a colour change, else saturate at 255.
  function automatic logic [7:0] dwell_next(input logic chg, input logic [7:0] dwell);
    logic [7:0] nxt;
    if (chg) begin
      nxt = 8'd1;
    end else if (dwell == 8'd255) begin
      nxt = dwell;
    end else begin
      nxt = dwell + 8'd1;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------- state
  state_t          state_r,        state_nxt_s;
  logic [SW-1:0]   start_cnt_r,    start_cnt_nxt_s;
  logic [BW-1:0]   blink_cnt_r,    blink_cnt_nxt_s;
  logic            blink_ph_r,     blink_ph_nxt_s;
  logic [2:0]      ns_col_r,       ew_col_r;
  logic [7:0]      ns_dwell_r,     ew_dwell_r;
  logic            ns_primed_r,    ns_primed_nxt_s;
  logic            ew_primed_r,    ew_primed_nxt_s;
  logic [2:0]      ns_out_r,       ns_out_nxt_s;
  logic [2:0]      ew_out_r,       ew_out_nxt_s;
  logic            fault_r,        fault_nxt_s;
  logic [2:0]      fault_code_r,   fault_code_nxt_s;

  // ---------------------------------------------------------------- inputs
  logic [2:0] ns_lamp_s;
  logic [2:0] ew_lamp_s;
  logic       ns_chg_s;
  logic       ew_chg_s;
  logic       short_yellow_s;
  logic       short_green_s;
  logic       conflict_s;
  logic [2:0] det_code_s;
  logic       enter_mon_s;

  assign ns_lamp_s = {bus.NS_red, bus.NS_yellow, bus.NS_green};
  assign ew_lamp_s = {bus.EW_red, bus.EW_yellow, bus.EW_green};
  assign ns_chg_s  = (ns_lamp_s != ns_col_r);
  assign ew_chg_s  = (ew_lamp_s != ew_col_r);

  // Both directions away from red at once lets crossing traffic move together.
  assign conflict_s = ~bus.NS_red & ~bus.EW_red;

  // Dwell violations only count for colour periods that started in MONITOR.
  assign short_yellow_s =
      (ns_chg_s && ns_primed_r && (ns_col_r == COL_YELLOW) && (ns_dwell_r < MIN_Y8)) ||
      (ew_chg_s && ew_primed_r && (ew_col_r == COL_YELLOW) && (ew_dwell_r < MIN_Y8));
  assign short_green_s =
      (ns_chg_s && ns_primed_r && (ns_col_r == COL_GREEN) && (ns_dwell_r < MIN_G8)) ||
      (ew_chg_s && ew_primed_r && (ew_col_r == COL_GREEN) && (ew_dwell_r < MIN_G8));

  assign enter_mon_s = (state_r != ST_MONITOR) && (state_nxt_s == ST_MONITOR);

  // Fault cause priority encoder: lowest code wins when several fire together.
  always_comb begin
    det_code_s = 3'd0;
    if (!lamp_valid(ns_lamp_s)) begin
      det_code_s = 3'd1;
    end else if (!lamp_valid(ew_lamp_s)) begin
      det_code_s = 3'd2;
    end else if (conflict_s) begin
      det_code_s = 3'd3;
    end else if (short_yellow_s) begin
      det_code_s = 3'd4;
    end else if (short_green_s) begin
      det_code_s = 3'd5;
    end else begin
      det_code_s = 3'd0;
    end
  end

  // State register and all sequential bookkeeping; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_INIT;
      start_cnt_r  <= '0;
      blink_cnt_r  <= '0;
      blink_ph_r   <= 1'b1;
      ns_col_r     <= 3'b000;
      ew_col_r     <= 3'b000;
      ns_dwell_r   <= 8'd0;
      ew_dwell_r   <= 8'd0;
      ns_primed_r  <= 1'b0;
      ew_primed_r  <= 1'b0;
      ns_out_r     <= COL_RED;
      ew_out_r     <= COL_RED;
      fault_r      <= 1'b0;
      fault_code_r <= 3'd0;
    end else begin
      state_r      <= state_nxt_s;
      start_cnt_r  <= start_cnt_nxt_s;
      blink_cnt_r  <= blink_cnt_nxt_s;
      blink_ph_r   <= blink_ph_nxt_s;
      ns_col_r     <= ns_lamp_s;
      ew_col_r     <= ew_lamp_s;
      ns_dwell_r   <= dwell_next(ns_chg_s, ns_dwell_r);
      ew_dwell_r   <= dwell_next(ew_chg_s, ew_dwell_r);
      ns_primed_r  <= ns_primed_nxt_s;
      ew_primed_r  <= ew_primed_nxt_s;
      ns_out_r     <= ns_out_nxt_s;
      ew_out_r     <= ew_out_nxt_s;
      fault_r      <= fault_nxt_s;
      fault_code_r <= fault_code_nxt_s;
    end
  end

  // Next-state logic: startup timeout, fault latch, operator acknowledge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (start_cnt_r == START_LAST) begin
          state_nxt_s = ST_MONITOR;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_MONITOR: begin
        if (det_code_s != 3'd0) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_MONITOR;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Counter, flag and output next values derived from the current and next state.
  always_comb begin
    start_cnt_nxt_s  = '0;
    blink_cnt_nxt_s  = '0;
    blink_ph_nxt_s   = 1'b1;
    ns_primed_nxt_s  = ns_primed_r;
    ew_primed_nxt_s  = ew_primed_r;
    ns_out_nxt_s     = COL_RED;
    ew_out_nxt_s     = COL_RED;
    fault_nxt_s      = 1'b0;
    fault_code_nxt_s = fault_code_r;

    // startup counter runs only while staying in INIT; any entry restarts it
    if ((state_r == ST_INIT) && (state_nxt_s == ST_INIT)) begin
      start_cnt_nxt_s = start_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      start_cnt_nxt_s = '0;
    end

    // flash phase starts lit on FAULT entry and toggles every BLINK_HALF cycles
    if ((state_r == ST_FAULT) && (state_nxt_s == ST_FAULT)) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_nxt_s = '0;
        blink_ph_nxt_s  = ~blink_ph_r;
      end else begin
        blink_cnt_nxt_s = blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
        blink_ph_nxt_s  = blink_ph_r;
      end
    end else begin
      blink_cnt_nxt_s = '0;
      blink_ph_nxt_s  = 1'b1;
    end

    // primed flags: cleared on MONITOR entry, set by the first colour change inside it
    if (enter_mon_s) begin
      ns_primed_nxt_s = 1'b0;
      ew_primed_nxt_s = 1'b0;
    end else if (state_r == ST_MONITOR) begin
      ns_primed_nxt_s = ns_primed_r | ns_chg_s;
      ew_primed_nxt_s = ew_primed_r | ew_chg_s;
    end else begin
      ns_primed_nxt_s = ns_primed_r;
      ew_primed_nxt_s = ew_primed_r;
    end

    // lamp drives: flash in FAULT, pass-through in MONITOR, all-red otherwise
    // (the INIT->MONITOR edge itself still shows all-red)
    if (state_nxt_s == ST_FAULT) begin
      ns_out_nxt_s = {blink_ph_nxt_s, 2'b00};
      ew_out_nxt_s = {blink_ph_nxt_s, 2'b00};
    end else if (state_r == ST_MONITOR) begin
      ns_out_nxt_s = ns_lamp_s;
      ew_out_nxt_s = ew_lamp_s;
    end else begin
      ns_out_nxt_s = COL_RED;
      ew_out_nxt_s = COL_RED;
    end

    fault_nxt_s = (state_nxt_s == ST_FAULT);

    // fault code: captured on the detecting edge, held in FAULT, zeroed on acknowledge
    if ((state_r == ST_MONITOR) && (state_nxt_s == ST_FAULT)) begin
      fault_code_nxt_s = det_code_s;
    end else if ((state_r == ST_FAULT) && (state_nxt_s == ST_INIT)) begin
      fault_code_nxt_s = 3'd0;
    end else begin
      fault_code_nxt_s = fault_code_r;
    end
  end

  assign bus.NS_red_o    = ns_out_r[2];
  assign bus.NS_yellow_o = ns_out_r[1];
  assign bus.NS_green_o  = ns_out_r[0];
  assign bus.EW_red_o    = ew_out_r[2];
  assign bus.EW_yellow_o = ew_out_r[1];
  assign bus.EW_green_o  = ew_out_r[0];
  assign bus.fault       = fault_r;
  assign bus.fault_code  = fault_code_r;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor. Lamp vectors are written as
// {NS r,y,g, EW r,y,g}; 6'b100100 is all-red.
module tb_traffic_lamp_monitor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  traffic_lamp_monitor_if bus_if ();

  traffic_lamp_monitor #(
    .STARTUP_CYCLES(16),
    .MIN_GREEN(8),
    .MIN_YELLOW(3),
    .BLINK_HALF(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] lamps, input logic clr);
    {bus_if.NS_red, bus_if.NS_yellow, bus_if.NS_green,
     bus_if.EW_red, bus_if.EW_yellow, bus_if.EW_green} = lamps;
    bus_if.fault_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {2'b00, bus_if.NS_red_o, bus_if.NS_yellow_o, bus_if.NS_green_o,
              bus_if.EW_red_o, bus_if.EW_yellow_o, bus_if.EW_green_o}, {2'b00, exp});
  endtask

  task automatic chk_flt(input string tag, input logic f, input logic [2:0] code);
    chk(tag, {4'd0, bus_if.fault, bus_if.fault_code}, {4'd0, f, code});
  endtask

  // standard 30-cycle plan: NS green 11 / yellow 4, then EW green 11 / yellow 4
  function automatic logic [5:0] plan(input int t);
    int p;
    p = t % 30;
    if (p < 11)      return 6'b001100;
    else if (p < 15) return 6'b010100;
    else if (p < 26) return 6'b100001;
    else             return 6'b100010;
  endfunction

  // after an INIT entry edge: 16 all-red edges, then pass-through of 'lamps'
  task automatic startup(input string tag, input logic [5:0] lamps, input logic clr);
    drive(lamps, clr);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk_out(tag, 6'b100100);
    end
    tick();
    chk_out(tag, lamps);
    chk_flt(tag, 1'b0, 3'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(6'b001001, 1'b1);

    // reset state
    tick();
    tick();
    chk_out("reset_out", 6'b100100);
    chk_flt("reset_flt", 1'b0, 3'd0);

    // normal cycling: 16 red edges, then 1-cycle tracking, no fault for 200 cycles
    rst = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      drive(plan(k - 1), 1'b0);
      tick();
      if (k <= 16) chk_out("startup_red", 6'b100100);
      else         chk_out("track", plan(k - 1));
      chk_flt("no_fault", 1'b0, 3'd0);
    end

    // green/green conflict -> code 3 at the same edge, flash 4 on / 4 off
    drive(6'b001001, 1'b0);
    tick();
    chk_flt("conflict", 1'b1, 3'd3);
    chk_out("flash_0", 6'b100100);
    drive(6'b000000, 1'b0);             // further faults ignored in FAULT
    for (int j = 1; j <= 11; j++) begin
      tick();
      chk_out("flash", ((j / 4) % 2 == 0) ? 6'b100100 : 6'b000000);
      chk_flt("flash_hold", 1'b1, 3'd3);
    end

    // acknowledge: fault clears at the edge, 16 red edges, then MONITOR
    drive(6'b000000, 1'b1);
    tick();
    chk_flt("clr", 1'b0, 3'd0);
    chk_out("clr_out", 6'b100100);
    startup("clr_start", 6'b001100, 1'b0);

    // acknowledge in MONITOR has no effect
    drive(6'b001100, 1'b1);
    tick();
    chk_flt("clr_mon", 1'b0, 3'd0);
    chk_out("clr_mon_out", 6'b001100);

    // NS green->yellow primes (green began in INIT); yellow 2 cycles then red -> 4
    drive(6'b010100, 1'b0);
    tick();
    chk_flt("prime_ns", 1'b0, 3'd0);
    tick();
    chk_out("yellow2", 6'b010100);
    drive(6'b100100, 1'b0);
    tick();
    chk_flt("short_yellow", 1'b1, 3'd4);
    chk_out("short_yellow_out", 6'b100100);

    // clear, then EW red->green primes; green 5 cycles then yellow -> 5
    drive(6'b100100, 1'b1);
    tick();
    chk_flt("clr2", 1'b0, 3'd0);
    startup("clr2_start", 6'b100100, 1'b0);
    drive(6'b100001, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk_flt("ew_green", 1'b0, 3'd0);
    end
    drive(6'b100010, 1'b0);
    tick();
    chk_flt("short_green", 1'b1, 3'd5);

    // NS encoding fault together with a both-non-red conflict -> lowest code 1
    drive(6'b100100, 1'b1);
    tick();
    startup("clr3_start", 6'b100100, 1'b0);
    drive(6'b011001, 1'b0);
    tick();
    chk_flt("multi", 1'b1, 3'd1);

    // reset mid-flash (dark phase) with a concurrent acknowledge
    drive(6'b100100, 1'b0);
    for (int j = 1; j <= 5; j++) tick();
    chk_out("mid_flash", 6'b000000);
    rst = 1'b0;
    drive(6'b100100, 1'b1);
    tick();
    chk_out("rst_flash_out", 6'b100100);
    chk_flt("rst_flash_flt", 1'b0, 3'd0);

    // acknowledge held high through INIT and MONITOR is ignored
    rst = 1'b1;
    startup("rst_start", 6'b100001, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
